traffic_phase_scheduler: RTL

Round-robin phase scheduler for a four-approach signalised intersection, with an optional pedestrian walk phase. Each approach has a level vehicle-demand sensor. The block owns the signal sequence: the green, yellow and all-red clearance dwell times, measured in prescaled ticks, plus demand-driven gap-out and max-out. It drives the per-approach lamp outputs directly and sits above the lamp drivers as the sole sequencer of the intersection.

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/traffic_tick_timer.sv | 45 ++++
 rtl/traffic_phase_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and default timing for the traffic phase scheduler.
// Macro PED_PHASE_EN adds the WALK phase and its dwell constant.
package traffic_pkg;

    localparam int N_APPR = 4;
    localparam int IDX_W  = 2;

    localparam int DEF_TICK_DIV  = 4;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_MIN_GREEN = 3;
    localparam int DEF_MAX_GREEN = 6;
    localparam int DEF_YELLOW_T  = 2;
    localparam int DEF_ALLRED_T  = 1;
`ifdef PED_PHASE_EN
    localparam int DEF_WALK_T    = 4;

    typedef enum logic [2:0] {ALLRED, GREEN, YELLOW, WALK} phase_e;
`else
    typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} phase_e;
`endif

    function automatic logic [N_APPR-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_APPR-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/traffic_tick_timer.sv
// Prescaler plus saturating tick counter; restart zeroes both so every
// phase dwell is measured from its own entry edge.
module traffic_tick_timer #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [CNT_W-1:0] thr,
    output logic             tick,
    output logic             expired
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    assign tick = (presc_q == PS_W'(TICK_DIV - 1));
    // >= rather than == so a phase resting past its dwell still sees expiry each tick
    assign expired = tick && (timer_q >= thr - CNT_W'(1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        timer_d = timer_q;
        if (tick && (timer_q != '1))
            timer_d = timer_q + CNT_W'(1);
        if (restart) begin
            presc_d = '0;
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            timer_q <= '0;
        end else begin
            presc_q <= presc_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Round-robin four-approach signal sequencer with gap-out / max-out.
// Macro PED_PHASE_EN enables the pedestrian WALK phase.
module traffic_phase_scheduler import traffic_pkg::*; #(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T
`ifdef PED_PHASE_EN
    ,
    parameter int WALK_T    = DEF_WALK_T
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic        ped_req,
    output logic [3:0]  green,
    output logic [3:0]  yellow,
    output logic [3:0]  red,
    output logic        ped_walk,
    output logic [1:0]  cur_idx
);

    phase_e             state_q, state_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [CNT_W-1:0]   thr;
    logic [N_APPR-1:0]  own;
    logic               restart, expired, competing, unused_tick;

    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_APPR-1:0] r,
                                                 input logic [IDX_W-1:0]  last);
        logic [IDX_W-1:0] idx, win;
        win = last;
        // walk from farthest to nearest so the nearest requester after last wins
        for (int k = N_APPR; k >= 1; k--) begin
            idx = last + IDX_W'(k);
            if (r[idx]) win = idx;
        end
        return win;
    endfunction

    assign own = onehot(cur_idx_q);

`ifdef PED_PHASE_EN
    logic ped_pending_q, ped_pending_d;

    assign competing     = |(req & ~own) || ped_pending_q;
    assign ped_pending_d = ped_req || (ped_pending_q && !(state_d == WALK && state_q != WALK));
    assign ped_walk      = (state_q == WALK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ped_pending_q <= 1'b0;
        else        ped_pending_q <= ped_pending_d;
    end
`else
    logic unused_ped;

    assign unused_ped = ped_req;
    assign competing  = |(req & ~own);
    assign ped_walk   = 1'b0;
`endif

    // In GREEN, own demand holds the light to max-out, otherwise gap-out at min.
    always_comb begin
        thr = CNT_W'(ALLRED_T);
        case (state_q)
            GREEN:   thr = req[cur_idx_q] ? CNT_W'(MAX_GREEN) : CNT_W'(MIN_GREEN);
            YELLOW:  thr = CNT_W'(YELLOW_T);
`ifdef PED_PHASE_EN
            WALK:    thr = CNT_W'(WALK_T);
`endif
            default: thr = CNT_W'(ALLRED_T);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        case (state_q)
            ALLRED: if (expired) begin
                if (|req) begin
                    state_d   = GREEN;
                    cur_idx_d = rr_pick(req, cur_idx_q);
                end
`ifdef PED_PHASE_EN
                if (ped_pending_q) begin
                    state_d   = WALK;
                    cur_idx_d = cur_idx_q;
                end
`endif
            end
            GREEN:   if (expired && competing) state_d = YELLOW;
            YELLOW:  if (expired) state_d = ALLRED;
`ifdef PED_PHASE_EN
            WALK:    if (expired) state_d = ALLRED;
`endif
            default: state_d = ALLRED;
        endcase
    end

    assign restart = (state_d != state_q);

    traffic_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .thr     (thr),
        .tick    (unused_tick),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ALLRED;
            cur_idx_q <= 2'd3;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
        end
    end

    assign green   = (state_q == GREEN)  ? own : '0;
    assign yellow  = (state_q == YELLOW) ? own : '0;
    assign red     = ~(green | yellow);
    assign cur_idx = cur_idx_q;

endmodule
